// File: rtl/crc_stream_if.sv
// crc_stream_if: input/output beat streams plus CRC result signals of the CRC engine
interface crc_stream_if #(
  parameter int DW = 8,
  parameter int CW = 16
);
  logic          mode;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] crc_out;
  logic          chk_valid;
  logic          chk_ok;
  modport slave (
    input  mode, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, crc_out, chk_valid, chk_ok
  );
  modport master (
    output mode, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, crc_out, chk_valid, chk_ok
  );
endinterface

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC generator (appends CRC beats) / checker (flags residue match)
module crc_stream_engine #(
  parameter int            DW      = 8,
  parameter int            CW      = 16,
  parameter logic [CW-1:0] POLY    = 'h8005,
  parameter logic [CW-1:0] INIT    = '0,
  parameter logic [CW-1:0] XOROUT  = '0,
  parameter logic [CW-1:0] RESIDUE = '0
) (
  input logic         clk,
  input logic         rst,
  crc_stream_if.slave bus
);
  localparam int NB = CW / DW;
  localparam int NW = $clog2(NB + 1);
  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] crc_q, crc_d, sh_q, sh_d, crc_out_q, crc_out_d, crc_next;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] md_q, md_d;
  logic          mode_q, mode_d, en_q, mv_q, mv_d, ml_q, ml_d, cv_q, cv_d, ok_q, ok_d;
  logic          free, acc, md_eff;
  // One LFSR step per data bit, MSB of the beat first
  for (genvar i = 0; i < DW; i++) begin : g_lfsr
    logic [CW-1:0] c_in, c;
    if (i == 0) begin : g_first
      assign c_in = crc_q;
    end else begin : g_next
      assign c_in = g_lfsr[i-1].c;
    end
    assign c = {c_in[CW-2:0], 1'b0} ^ ((c_in[CW-1] ^ bus.s_data[DW-1-i]) ? POLY : '0);
  end
  assign crc_next      = g_lfsr[DW-1].c;
  assign free          = !mv_q || bus.m_ready;
  assign bus.s_ready   = en_q && state_q != APPEND && free;
  assign acc           = bus.s_valid && bus.s_ready;
  assign md_eff        = state_q == IDLE ? bus.mode : mode_q;
  assign bus.m_valid   = mv_q;
  assign bus.m_data    = md_q;
  assign bus.m_last    = ml_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.chk_valid = cv_q;
  assign bus.chk_ok    = ok_q;
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    crc_out_d = crc_out_q;
    mode_d    = mode_q;
    mv_d      = mv_q;
    md_d      = md_q;
    ml_d      = ml_q;
    ok_d      = ok_q;
    cv_d      = 1'b0;
    if (acc) begin
      mv_d    = 1'b1;
      md_d    = bus.s_data;
      ml_d    = bus.s_last && md_eff;
      mode_d  = md_eff;
      crc_d   = crc_next;
      state_d = DATA;
      if (bus.s_last) begin
        crc_d     = INIT;
        crc_out_d = crc_next ^ XOROUT;
        sh_d      = crc_next ^ XOROUT;
        cnt_d     = NW'(NB);
        cv_d      = md_eff;
        ok_d      = md_eff ? crc_next == RESIDUE : ok_q;
        state_d   = md_eff ? IDLE : APPEND;
      end
    end else if (state_q == APPEND && free && cnt_q != '0) begin
      mv_d  = 1'b1;
      md_d  = sh_q[CW-1 -: DW];
      ml_d  = cnt_q == NW'(1);
      sh_d  = sh_q << DW;
      cnt_d = cnt_q - NW'(1);
    end else if (mv_q && bus.m_ready) begin
      mv_d    = 1'b0;
      state_d = state_q == APPEND ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      sh_q      <= '0;
      cnt_q     <= '0;
      crc_out_q <= '0;
      mode_q    <= 1'b0;
      en_q      <= 1'b0;
      mv_q      <= 1'b0;
      md_q      <= '0;
      ml_q      <= 1'b0;
      cv_q      <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      crc_out_q <= crc_out_d;
      mode_q    <= mode_d;
      en_q      <= 1'b1;
      mv_q      <= mv_d;
      md_q      <= md_d;
      ml_q      <= ml_d;
      cv_q      <= cv_d;
      ok_q      <= ok_d;
    end
  end
endmodule
